reg_writer: RTL and testbench
=============================

# reg_writer

Write-back side of the register bank: owns the 64-entry register array (32 general + 32 float) and drives the flattened `regsout` bus that `reg_reader` selects from. Write requests enter through a valid/ready handshake into a small in-order queue and are committed one per cycle while `commit_en` is high. A per-register `pending` vector marks registers with a queued but uncommitted write, so the issue stage can hold dependent reads.

## Interface
Parameters:
- `DEPTH`, 4: write-queue entries; power of two, ≥ 2.
- `` `WIDTH `` and `` `NUM `` (=64) come from `common.h`; they are not module parameters.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `w_valid`  in  1  write request present.
- `w_ready`  out  1  queue can accept; `w_ready = !full`, combinational from queue count only.
- `w_gfflag`  in  1  0: general, 1: float.
- `w_num`  in  5  register number.
- `w_data`  in  `` `WIDTH ``  write value.
- `commit_en`  in  1  allow head of queue to commit this cycle.
- `regsout`  out  `` `WIDTH*`NUM ``  register array; slot `{gfflag,num}` occupies bits `[WIDTH*(idx+1)-1 : WIDTH*idx]`; general in the low half, float in the high half.
- `pending`  out  `` `NUM ``  bit `idx` set while any valid queue entry targets `idx`.

## Operation
- Index: `idx = {w_gfflag, w_num}` (6 bits, 0..63).
- Enqueue: `w_valid && w_ready` at an edge writes `{idx, w_data}` at the tail; tail and count advance.
- Commit: at an edge with `commit_en && !empty`, the head entry is written into `regsout[idx]`; head advances and count decrements.
- Simultaneous enqueue and commit: both take effect; count is unchanged. When full, `w_ready=0` even if a commit happens in the same cycle. No bypass into a full queue.
- Empty queue, `commit_en=1`: no change.
- Order: strictly FIFO. Multiple queued writes to one register commit in order; the last one wins.
- `pending[i]` = OR over valid entries of `(entry.idx == i)`. It is combinational from queue state and clears in the cycle after the last matching entry commits.
- Pointers wrap modulo `DEPTH`. Count runs 0..DEPTH; `full = (count==DEPTH)`, `empty = (count==0)`.
- Write data is never modified; no width conversion.

## Timing
- Reset (async assert, any cycle): `regsout` = all zero, queue empty, `pending` = 0, `w_ready` = 1. In-flight queued writes are discarded.
- Latency: a write accepted at edge N with an empty queue and `commit_en=1` at edge N+1 is visible on `regsout` after edge N+1. `pending` for it is high between edge N and edge N+1.
- `regsout` is registered; `reg_reader` adds its own cycle on top.
- `commit_en` low for K cycles delays commits by exactly K cycles. Accepts continue until full.

## Configuration
- `` `define GR0_ZERO_EN ``
  - Defined: general register 0 (`idx=0`) is hardwired zero. Writes to it are accepted and queued to keep ordering, but never set `pending[0]` and never change `regsout[0]`. Float register 0 (`idx=32`) stays writable.
  - Undefined: `idx=0` behaves like every other slot.

## Structure
- `common.h` holds `` `WIDTH ``, `` `NUM ``, and a shared `` `REG_IDX(gf,num) `` macro for the 6-bit index, used by both reader and writer.
- Sub-module `wb_fifo`: generic `DEPTH`-entry FIFO with `count`, `full`, `empty`, and exposed entry/valid vectors for the `pending` OR-reduction.
- `reg_writer` contains the array, the commit logic and the `pending` decode.

## Test plan
- Reset, then one write `gf=0, num=5, data=0x1234` with `commit_en=1` -> `pending[5]=1` for 1 cycle; `regsout` slot 5 = 0x1234 after 2 edges; all other slots stay 0.
- `commit_en=0`, push 4 writes (float 1..4 = 0xA..0xD) -> `w_ready=0` after the 4th, `pending[33..36]=1`; raise `commit_en` -> slots 33..36 updated on 4 consecutive edges, `w_ready=1` after the first commit.
- Two queued writes to general 7 (0x1 then 0x2) -> slot 7 = 0x2; `pending[7]` stays high until the second commits.
- Full queue with `w_valid=1` and `commit_en=1` on the same edge -> one commit, no accept; accept on the next edge; no data lost or duplicated.
- Write general 0 = 0xFFFF -> with `GR0_ZERO_EN`: slot 0 stays 0 and `pending[0]` never rises. Without it: slot 0 = 0xFFFF. Write float 0 -> slot 32 updated in both builds.
- Assert `rstn=0` mid-drain with 3 entries queued -> immediately `regsout=0`, `pending=0`, `w_ready=1`; no commit after release.

Source files
------------

// File: rtl/reg_writer_pkg.sv
// Shared types and sizes for the register write-back path (replaces the
// WIDTH/NUM/REG_IDX definitions of the common header).
package reg_writer_pkg;

  localparam int WIDTH = 32;
  localparam int NUM   = 64;
  localparam int IDX_W = 6;

  typedef logic [IDX_W-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t         idx;
    logic [WIDTH-1:0] data;
  } wb_entry_t;

  // Flat slot index: general registers in 0..31, float registers in 32..63.
  function automatic reg_idx_t reg_idx(input logic gfflag, input logic [4:0] num);
    return {gfflag, num};
  endfunction

endpackage

// File: rtl/reg_writer_wb_fifo.sv
// wb_fifo: in-order DEPTH-entry write queue; exposes every entry and its valid
// bit so the owner can decode which registers have writes in flight.
module wb_fifo
  import reg_writer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output wb_entry_t             head_entry,
  output wb_entry_t [DEPTH-1:0] entries,
  output logic [DEPTH-1:0]      valid
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  wb_entry_t        mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap for free because DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: queue storage is deliberately not reset; the valid vector derived
  // from head/count is what qualifies each entry.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= push_entry;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    logic [PTR_W-1:0] offset;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset     = PTR_W'(i) - head;
      valid[i]   = ((PTR_W+1)'(offset) < count);
      entries[i] = mem[i];
    end
  end

  assign head_entry = mem[head];

endmodule

// File: rtl/reg_writer.sv
// reg_writer: 64-slot register array fed by an in-order write queue, plus the
// per-register pending vector. Define GR0_ZERO_EN to hardwire general reg 0.
module reg_writer
  import reg_writer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  logic                   w_gfflag,
  input  logic [4:0]             w_num,
  input  logic [WIDTH-1:0]       w_data,
  input  logic                   commit_en,
  output logic [WIDTH*NUM-1:0]   regsout,
  output logic [NUM-1:0]         pending
);

  logic                  full;
  logic                  empty;
  logic                  commit;
  logic                  commit_wr;
  wb_entry_t             push_entry;
  wb_entry_t             head_entry;
  wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      valid;

  assign push_entry = '{idx: reg_idx(w_gfflag, w_num), data: w_data};
  assign w_ready    = !full;
  assign commit     = commit_en && !empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .push       (w_valid),
    .push_entry (push_entry),
    .pop        (commit),
    .full       (full),
    .empty      (empty),
    .head_entry (head_entry),
    .entries    (entries),
    .valid      (valid)
  );

  // Writes to general reg 0 still drain through the queue to keep ordering.
`ifdef GR0_ZERO_EN
  assign commit_wr = commit && (head_entry.idx != '0);
`else
  assign commit_wr = commit;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      regsout <= '0;
    end else if (commit_wr) begin
      regsout[int'(head_entry.idx)*WIDTH +: WIDTH] <= head_entry.data;
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i]) pending[entries[i].idx] = 1'b1;
    end
`ifdef GR0_ZERO_EN
    pending[0] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_reg_writer.sv
// Scoreboard bench for reg_writer: a behavioural queue model feeds expected
// commits to a monitor; directed steps add hand-computed spot values.
module tb_reg_writer;
  import reg_writer_pkg::*;

  localparam int DEPTH = 4;
`ifdef GR0_ZERO_EN
  localparam bit GR0 = 1'b1;
`else
  localparam bit GR0 = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 w_valid = 1'b0;
  logic                 w_gfflag = 1'b0;
  logic [4:0]           w_num = '0;
  logic [WIDTH-1:0]     w_data = '0;
  logic                 commit_en = 1'b0;
  logic                 w_ready;
  logic [WIDTH*NUM-1:0] regsout;
  logic [NUM-1:0]       pending;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [5:0]       idx;
    logic [WIDTH-1:0] data;
  } ent_t;

  ent_t             mq[$];
  ent_t             exp_q[$];
  logic [WIDTH-1:0] mmem [NUM];

  reg_writer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_gfflag  (w_gfflag),
    .w_num     (w_num),
    .w_data    (w_data),
    .commit_en (commit_en),
    .regsout   (regsout),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] slot(input int i);
    return regsout[i*WIDTH +: WIDTH];
  endfunction

  // Reference model: updates on the same edges the DUT does.
  initial begin
    foreach (mmem[i]) mmem[i] = '0;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        mq.delete();
        exp_q.delete();
        foreach (mmem[i]) mmem[i] = '0;
      end else begin
        bit   acc;
        bit   com;
        ent_t e;
        acc = w_valid && (mq.size() < DEPTH);
        com = commit_en && (mq.size() > 0);
        if (com) begin
          e = mq.pop_front();
          if (!(GR0 && e.idx == 6'd0)) mmem[e.idx] = e.data;
          exp_q.push_back(e);
        end
        if (acc) begin
          e.idx  = {w_gfflag, w_num};
          e.data = w_data;
          mq.push_back(e);
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the model on every falling edge.
  initial begin
    forever begin
      logic [NUM-1:0]   exp_pend;
      logic [WIDTH-1:0] exp_val;
      ent_t             e;
      @(negedge clk);
      exp_pend = '0;
      foreach (mq[k]) exp_pend[mq[k].idx] = 1'b1;
      if (GR0) exp_pend[0] = 1'b0;
      check("mon_w_ready", 64'(w_ready), 64'(mq.size() < DEPTH));
      check("mon_pending", 64'(pending), 64'(exp_pend));
      for (int s = 0; s < NUM; s++) check($sformatf("mon_slot%0d", s), 64'(slot(s)), 64'(mmem[s]));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        exp_val = (GR0 && e.idx == 6'd0) ? '0 : e.data;
        check($sformatf("commit_idx%0d", e.idx), 64'(slot(int'(e.idx))), 64'(exp_val));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input bit gf, input int num, input logic [WIDTH-1:0] d);
    w_valid  = 1'b1;
    w_gfflag = gf;
    w_num    = 5'(num);
    w_data   = d;
  endtask

  initial begin
    step();
    step();
    check("rst_ready", 64'(w_ready), 64'd1);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_regs_or", 64'(|regsout), 64'd0);
    rstn = 1'b1;
    step();

    // Single write, immediate commit.
    commit_en = 1'b1;
    put(0, 5, 32'h1234);
    step();
    w_valid = 1'b0;
    check("t1_pending5", 64'(pending[5]), 64'd1);
    check("t1_slot5_before", 64'(slot(5)), 64'd0);
    step();
    check("t1_pending5_clear", 64'(pending[5]), 64'd0);
    check("t1_slot5", 64'(slot(5)), 64'h1234);

    // Fill the queue with commits held off, then drain.
    commit_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      put(1, i, WIDTH'(32'hA + i - 1));
      step();
    end
    w_valid = 1'b0;
    check("t2_full_ready", 64'(w_ready), 64'd0);
    check("t2_pending", 64'(pending[36:33]), 64'hF);
    commit_en = 1'b1;
    step();
    check("t2_slot33", 64'(slot(33)), 64'hA);
    check("t2_ready_after1", 64'(w_ready), 64'd1);
    step();
    step();
    step();
    check("t2_slot36", 64'(slot(36)), 64'hD);

    // Two writes to one register: last one wins.
    commit_en = 1'b0;
    put(0, 7, 32'h1);
    step();
    put(0, 7, 32'h2);
    step();
    w_valid   = 1'b0;
    commit_en = 1'b1;
    step();
    check("t3_slot7_first", 64'(slot(7)), 64'h1);
    check("t3_pending7_held", 64'(pending[7]), 64'd1);
    step();
    check("t3_slot7_last", 64'(slot(7)), 64'h2);
    check("t3_pending7_clear", 64'(pending[7]), 64'd0);

    // Full queue with request and commit on the same edge.
    commit_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put(0, 10 + i, WIDTH'(32'h100 + i));
      step();
    end
    check("t4_full", 64'(w_ready), 64'd0);
    put(0, 14, 32'h200);
    commit_en = 1'b1;
    step();
    check("t4_slot10", 64'(slot(10)), 64'h100);
    check("t4_no_accept", 64'(pending[14]), 64'd0);
    check("t4_ready_again", 64'(w_ready), 64'd1);
    step();
    w_valid = 1'b0;
    check("t4_accepted", 64'(pending[14]), 64'd1);
    step();
    step();
    step();
    step();
    check("t4_slot13", 64'(slot(13)), 64'h103);
    check("t4_slot14", 64'(slot(14)), 64'h200);
    check("t4_drained", 64'(pending), 64'd0);

    // General reg 0 and float reg 0.
    put(0, 0, 32'hFFFF);
    step();
    w_valid = 1'b0;
    check("t5_pending0", 64'(pending[0]), GR0 ? 64'd0 : 64'd1);
    step();
    check("t5_slot0", 64'(slot(0)), GR0 ? 64'd0 : 64'hFFFF);
    put(1, 0, 32'h5A5A);
    step();
    w_valid = 1'b0;
    check("t5_pending32", 64'(pending[32]), 64'd1);
    step();
    check("t5_slot32", 64'(slot(32)), 64'h5A5A);

    // Reset while draining.
    commit_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(0, 20 + i, WIDTH'(32'hC0 + i));
      step();
    end
    w_valid   = 1'b0;
    commit_en = 1'b1;
    step();
    check("t6_slot20", 64'(slot(20)), 64'hC0);
    #2;
    rstn = 1'b0;
    #1;
    check("t6_rst_regs_or", 64'(|regsout), 64'd0);
    check("t6_rst_pending", 64'(pending), 64'd0);
    check("t6_rst_ready", 64'(w_ready), 64'd1);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    step();
    step();
    step();
    check("t6_no_commit_regs_or", 64'(|regsout), 64'd0);
    check("t6_no_commit_pending", 64'(pending), 64'd0);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
